// File: rtl/out_stream_collector_pkg.sv
// Shared sizes, FSM state encoding and the signature rotate helper for the
// output-stream collector.
package out_stream_collector_pkg;

  localparam int LANES         = 8;
  localparam int DATA_W        = 32;
  localparam int CNT_W         = 16;
  localparam int FRAME_NIBBLES = 12;
  localparam int FRAME_W       = DATA_W + CNT_W;
  localparam int POP_W         = $clog2(LANES + 1);
  localparam int NIB_W         = $clog2(FRAME_NIBBLES);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_FOLD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [DATA_W-1:0] rotl1(input logic [DATA_W-1:0] v);
    return {v[DATA_W-2:0], v[DATA_W-1]};
  endfunction

endpackage

// File: rtl/out_stream_if.sv
// The eight HLS ap_fifo write-side streams feeding the collector.
// Handshake: a word transfers on a clock edge where C_out_k_write & C_out_k_full_n.
interface out_stream_if;
  import out_stream_collector_pkg::*;

  logic [DATA_W-1:0] C_out_0_din, C_out_1_din, C_out_2_din, C_out_3_din;
  logic [DATA_W-1:0] C_out_4_din, C_out_5_din, C_out_6_din, C_out_7_din;
  logic C_out_0_write, C_out_1_write, C_out_2_write, C_out_3_write;
  logic C_out_4_write, C_out_5_write, C_out_6_write, C_out_7_write;
  logic C_out_0_full_n, C_out_1_full_n, C_out_2_full_n, C_out_3_full_n;
  logic C_out_4_full_n, C_out_5_full_n, C_out_6_full_n, C_out_7_full_n;

  modport master (
    output C_out_0_din, C_out_1_din, C_out_2_din, C_out_3_din,
           C_out_4_din, C_out_5_din, C_out_6_din, C_out_7_din,
    output C_out_0_write, C_out_1_write, C_out_2_write, C_out_3_write,
           C_out_4_write, C_out_5_write, C_out_6_write, C_out_7_write,
    input  C_out_0_full_n, C_out_1_full_n, C_out_2_full_n, C_out_3_full_n,
           C_out_4_full_n, C_out_5_full_n, C_out_6_full_n, C_out_7_full_n
  );

  modport slave (
    input  C_out_0_din, C_out_1_din, C_out_2_din, C_out_3_din,
           C_out_4_din, C_out_5_din, C_out_6_din, C_out_7_din,
    input  C_out_0_write, C_out_1_write, C_out_2_write, C_out_3_write,
           C_out_4_write, C_out_5_write, C_out_6_write, C_out_7_write,
    output C_out_0_full_n, C_out_1_full_n, C_out_2_full_n, C_out_3_full_n,
           C_out_4_full_n, C_out_5_full_n, C_out_6_full_n, C_out_7_full_n
  );

endinterface

// File: rtl/out_stream_collector_lane_sig_accum.sv
// One lane's rotate-XOR signature register; folds in a word only when accepted.
module lane_sig_accum
  import out_stream_collector_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (accept) begin
      sig <= rotl1(sig) ^ din;
    end
  end

endmodule

// File: rtl/out_stream_collector.sv
// Sink for the kernel output streams: per-lane signatures plus a saturating word
// count, reported as a 12-nibble frame after ap_done, with a pass/fail probe.
module out_stream_collector
  import out_stream_collector_pkg::*;
#(
  parameter int EXPECTED_WORDS = 4096
) (
  input  logic         ap_clk,
  input  logic         ap_rst_n,
  out_stream_if.slave  c_out,
  input  logic         ap_done,
  output logic [3:0]   data_out,
  output logic         data_valid,
  output logic         probe_out,
  output state_t       dbg_state
);

  state_t state, state_nxt;

  logic [DATA_W-1:0]  din [LANES];
  logic [DATA_W-1:0]  sig [LANES];
  logic [LANES-1:0]   wr;
  logic [LANES-1:0]   accept;
  logic [LANES-1:0]   bad_wr;
  logic               full_n;
  logic [POP_W-1:0]   pop;
  logic [CNT_W:0]     cnt_sum;
  logic [CNT_W-1:0]   total_cnt;
  logic [DATA_W-1:0]  sig_fold;
  logic [FRAME_W-1:0] shift_reg;
  logic [NIB_W-1:0]   nib_cnt;
  logic               err;
  logic               probe_q;

  assign din[0] = c_out.C_out_0_din;
  assign din[1] = c_out.C_out_1_din;
  assign din[2] = c_out.C_out_2_din;
  assign din[3] = c_out.C_out_3_din;
  assign din[4] = c_out.C_out_4_din;
  assign din[5] = c_out.C_out_5_din;
  assign din[6] = c_out.C_out_6_din;
  assign din[7] = c_out.C_out_7_din;

  assign wr = {c_out.C_out_7_write, c_out.C_out_6_write, c_out.C_out_5_write,
               c_out.C_out_4_write, c_out.C_out_3_write, c_out.C_out_2_write,
               c_out.C_out_1_write, c_out.C_out_0_write};

  // Streams are only open while accumulating; full_n decodes the state register.
  assign full_n = (state == ST_ACCUM);

  assign c_out.C_out_0_full_n = full_n;
  assign c_out.C_out_1_full_n = full_n;
  assign c_out.C_out_2_full_n = full_n;
  assign c_out.C_out_3_full_n = full_n;
  assign c_out.C_out_4_full_n = full_n;
  assign c_out.C_out_5_full_n = full_n;
  assign c_out.C_out_6_full_n = full_n;
  assign c_out.C_out_7_full_n = full_n;

  assign accept = wr & {LANES{full_n}};
  assign bad_wr = wr & {LANES{~full_n}};

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_sig_accum u_lane (
      .clk    (ap_clk),
      .rst_n  (ap_rst_n),
      .accept (accept[k]),
      .din    (din[k]),
      .sig    (sig[k])
    );
  end

  always_comb begin
    pop      = '0;
    sig_fold = '0;
    for (int k = 0; k < LANES; k++) begin
      pop      = pop + POP_W'(accept[k]);
      sig_fold = sig_fold ^ sig[k];
    end
  end

  assign cnt_sum = {1'b0, total_cnt} + (CNT_W+1)'(pop);

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      total_cnt <= '0;
    end else if (cnt_sum[CNT_W]) begin
      total_cnt <= '1;
    end else begin
      total_cnt <= cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_ACCUM: if (ap_done) state_nxt = ST_FOLD;
      ST_FOLD:  state_nxt = ST_SHIFT;
      ST_SHIFT: if (nib_cnt == NIB_W'(FRAME_NIBBLES - 1)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_DONE;
      default:  state_nxt = ST_ACCUM;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      shift_reg <= '0;
      nib_cnt   <= '0;
    end else if (state == ST_FOLD) begin
      shift_reg <= {sig_fold, total_cnt};
      nib_cnt   <= '0;
    end else if (state == ST_SHIFT) begin
      shift_reg <= shift_reg << 4;
      nib_cnt   <= nib_cnt + 1'b1;
    end
  end

  // A stray write on the last nibble still counts against the probe.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      err     <= 1'b0;
      probe_q <= 1'b0;
    end else begin
      if (|bad_wr) err <= 1'b1;
      if (state == ST_SHIFT && state_nxt == ST_DONE) begin
        probe_q <= (int'(total_cnt) == EXPECTED_WORDS) & ~(err | (|bad_wr));
      end
    end
  end

  assign data_valid = (state == ST_SHIFT);
  assign data_out   = (state == ST_SHIFT) ? shift_reg[FRAME_W-1 -: 4] : 4'h0;
  assign probe_out  = probe_q;
  assign dbg_state  = state;

endmodule

// File: doc/out_stream_collector.md
Name: out_stream_collector

Overview:
- Terminal sink for the 8 kernel output streams C_out_0..C_out_7 (HLS ap_fifo write side) inside the board wrapper.
- Per lane, accepts words and folds them into a rotate-XOR signature; also counts accepted words.
- On the kernel's ap_done, emits a 48-bit result frame (32-bit signature, 16-bit word count) as 12 nibbles on data_out/data_valid.
- Drives probe_out as the pass/fail indicator that the board exposes.

Parameters:
DATA_W, 32, width of each C_out_k_din word (signature width equals DATA_W)
LANES, 8, number of output streams
EXPECTED_WORDS, 4096, total word count over all lanes that constitutes a pass
CNT_W, 16, width of the total-word counter (saturating)

Ports:
ap_clk  in  1  system clock
ap_rst_n  in  1  asynchronous active-low reset
C_out_k_din (k=0..7)  in  DATA_W  stream k write data
C_out_k_write (k=0..7)  in  1  stream k write strobe
C_out_k_full_n (k=0..7)  out  1  stream k not-full; write accepted when write & full_n
ap_done  in  1  kernel completion pulse
data_out  out  4  result frame nibble
data_valid  out  1  data_out valid strobe
probe_out  out  1  pass indicator, valid in DONE

Behaviour:
- Reset: asynchronous on ap_rst_n low, released synchronously. Clock ap_clk, reset ap_rst_n (async, active-low) — fixed.
- Reset values: state=ACCUM; all lane signatures 0; total count 0; err 0; data_out 0; data_valid 0; probe_out 0; all full_n 1.
- States:
  - ACCUM: all full_n=1. Per accepted lane k: sig_k <= rotl1(sig_k) ^ C_out_k_din.
    - Total count += number of lanes accepted this cycle (0..8); saturates at 2^CNT_W-1.
    - ap_done -> FOLD. Writes in the same cycle as ap_done are accepted and counted.
  - FOLD: one cycle; all full_n=0. Loads shift reg = {XOR of sig_0..sig_7, total_count}, MSB first. -> SHIFT.
  - SHIFT: 12 cycles; all full_n=0. data_valid=1; data_out = top nibble; shift left 4 each cycle. Nibble counter 0..11; after nibble 11 -> DONE.
  - DONE: full_n=0; data_valid=0; data_out=0. probe_out = (total_count==EXPECTED_WORDS) & ~err, registered on entry and held. Remains in DONE until reset.
- Timing: ap_done sampled high at edge t -> FOLD cycle t+1 -> nibbles valid cycles t+2..t+13 -> DONE from t+14.
- Error conditions:
  - Any C_out_k_write while full_n=0 (FOLD/SHIFT/DONE) sets sticky err; data dropped, signature and count unchanged.
  - ap_done outside ACCUM is ignored.
- Count saturation: once at max, further writes do not wrap; the count stays at max and probe_out fails unless EXPECTED_WORDS equals max.
- Reset mid-frame: data_valid drops immediately (async), frame is abandoned, block returns to ACCUM.

Decomposition:
- Shared package: LANES, DATA_W, CNT_W, FRAME_NIBBLES=12, state enum {ACCUM, FOLD, SHIFT, DONE}, rotl1 function.
- One sub-module, lane_sig_accum: per-lane signature register with accept gating, instantiated LANES times.
- Top level holds the popcount adder, FSM, shift register and probe logic.

Test Plan:
1. Lane0 writes 0x00000001 once, then ap_done -> nibbles 0,0,0,0,0,0,0,1,0,0,0,1 on cycles t+2..t+13; probe_out=0 (EXPECTED_WORDS=4096).
2. Lane0 writes 0x80000000 then 0x00000001, ap_done -> signature 0x00000000, count 0x0002, frame 000000000002.
3. All 8 lanes write 512 words each, every cycle, ap_done on the final write cycle -> count 0x1000 (all words accepted), probe_out=1 from t+14.
4. After ap_done, lane3 asserts write during SHIFT -> full_n_3=0, frame unchanged, err set, probe_out=0 in DONE even with count 4096.
5. Assert ap_rst_n low at the 5th nibble -> data_valid=0 the same instant, all outputs at reset values. A subsequent clean run gives the correct frame.
6. Force 70000 accepted words -> count field 0xFFFF, no wrap, probe_out=0.
